decoder_rr_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 17 +
 rtl/decoder_rr_arbiter_if.sv | 14 +
 rtl/decoder.sv | 16 +
 rtl/decoder_rr_arbiter.sv | 114 +++++++++++
 tb/tb_decoder_rr_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared widths, FSM encoding and search-result type for the decoder round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } win_t;

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between requester logic (master) and the arbiter (slave).
interface decoder_rr_arbiter_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic [7:0]       hold_cnt;

    modport master (output req, input gnt_valid, gnt_idx, gnt, hold_cnt);
    modport slave  (input req, output gnt_valid, gnt_idx, gnt, hold_cnt);

endinterface

// File: rtl/decoder.sv
// 3-to-8 decoder with enable; all outputs low when E is low.
module decoder
    import arb_pkg::*;
(
    input  logic             E,
    input  logic [IDX_W-1:0] In,
    output logic [N_REQ-1:0] Out
);

    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        Out = '0;
        if (E) Out[In] = 1'b1;
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for eight requesters with a hold limit under contention;
// the grant index/enable feed a 3-to-8 decoder that produces the one-hot grant.
module decoder_rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic                clka,
    input  logic                rst,
    decoder_rr_arbiter_if.slave bus
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [IDX_W-1:0] last_q,  last_d;
    logic [7:0]       hold_q,  hold_d;

    logic [N_REQ-1:0] others;
    win_t             any_win;
    win_t             rot_win;

    // First set bit scanning from+1, from+2, ... wrapping; from itself is checked last.
    function automatic win_t next_winner(input logic [N_REQ-1:0] r,
                                         input logic [IDX_W-1:0] from);
        win_t             w;
        logic [IDX_W-1:0] cand;
        w.found = 1'b0;
        w.idx   = from;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = from + IDX_W'(k);
            if (r[cand]) begin
                w.found = 1'b1;
                w.idx   = cand;
            end
        end
        return w;
    endfunction

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        last_d  = last_q;
        hold_d  = hold_q;

        others  = bus.req & ~(N_REQ'(1) << idx_q);
        any_win = next_winner(bus.req, last_q);
        rot_win = next_winner(others, last_q);

        unique case (state_q)
            IDLE: begin
                if (any_win.found) begin
                    state_d = GRANT;
                    valid_d = 1'b1;
                    idx_d   = any_win.idx;
                    last_d  = any_win.idx;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!bus.req[idx_q]) begin
                    // Holder released: its bit is clear, so the plain search skips it.
                    if (any_win.found) begin
                        idx_d  = any_win.idx;
                        last_d = any_win.idx;
                        hold_d = '0;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else if (rot_win.found && hold_q == HOLD_MAX) begin
                    idx_d  = rot_win.idx;
                    last_d = rot_win.idx;
                    hold_d = '0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            hold_q  <= '0;
        end else begin
            // NOTE: non-blocking for all state so every flop samples pre-edge values.
            state_q <= state_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.gnt_valid = valid_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.hold_cnt  = hold_q;

    decoder u_decoder (
        .E   (valid_q),
        .In  (idx_q),
        .Out (bus.gnt)
    );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural arbiter model.
module tb_decoder_rr_arbiter;

    localparam int MAXH = 4;

    logic clka = 1'b0;
    logic rst  = 1'b1;

    decoder_rr_arbiter_if bus ();

    decoder_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clka = ~clka;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: who holds the grant, who won last, how long held.
    bit m_valid;
    int m_idx;
    int m_last;
    int m_hold;

    function automatic int find_after(input bit [7:0] r, input int after);
        for (int k = 1; k <= 8; k++) begin
            if (r[(after + k) % 8]) return (after + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_gnt();
        return m_valid ? (8'd1 << m_idx) : 8'd0;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_last  = 7;
        m_hold  = 0;
    endtask

    task automatic model_step(input bit [7:0] r);
        int      w;
        bit [7:0] o;
        if (!m_valid) begin
            w = find_after(r, m_last);
            if (w >= 0) begin
                m_valid = 1'b1; m_idx = w; m_last = w; m_hold = 0;
            end
        end else if (!r[m_idx]) begin
            w = find_after(r, m_last);
            if (w >= 0) begin
                m_idx = w; m_last = w; m_hold = 0;
            end else begin
                m_valid = 1'b0; m_hold = 0;
            end
        end else begin
            o = r;
            o[m_idx] = 1'b0;
            if (o != 0 && m_hold == MAXH - 1) begin
                w = find_after(o, m_last);
                m_idx = w; m_last = w; m_hold = 0;
            end else if (m_hold < MAXH - 1) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    // Drive req, let one rising edge pass, advance the model, sample 1 time unit later.
    task automatic tick(input bit [7:0] r);
        bus.req = r;
        @(posedge clka);
        model_step(r);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clka);
        rst = 1'b1;
        model_reset();
        @(negedge clka);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req = 8'hFF;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clka);
        #1;
        n_checks++;
        if (bus.gnt_valid !== 1'b0 || bus.gnt !== 8'h00 || bus.gnt_idx !== 3'd0 || bus.hold_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b gnt=%h idx=%0d hold=%0d, required all zero",
                     bus.gnt_valid, bus.gnt, bus.gnt_idx, bus.hold_cnt);
        end
        @(negedge clka);
        rst = 1'b0;
        tick(8'hFF);
        n_checks++;
        if (bus.gnt_idx !== 3'd0 || bus.gnt !== 8'h01 || bus.gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: idx=%0d gnt=%h valid=%b, required idx=0 gnt=01 valid=1",
                     bus.gnt_idx, bus.gnt, bus.gnt_valid);
        end
    endtask

    task automatic test_rotation();
        int      order[$];
        int      expd[4] = '{2, 5, 7, 2};
        bit [7:0] r;
        int      prev;
        apply_reset();
        r    = 8'hA4;
        prev = -1;
        for (int c = 0; c < 8; c++) begin
            tick(r);
            n_checks++;
            if (bus.gnt_valid !== 1'b1 || bus.gnt !== exp_gnt()) begin
                n_fail++;
                $display("FAIL rotation_cycle%0d: valid=%b gnt=%h, required valid=1 gnt=%h",
                         c, bus.gnt_valid, bus.gnt, exp_gnt());
            end
            if (int'(bus.gnt_idx) != prev) order.push_back(int'(bus.gnt_idx));
            prev = int'(bus.gnt_idx);
            r = 8'hA4;
            if (m_hold == 1) r[m_idx] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= order.size() || order[i] != expd[i]) begin
                n_fail++;
                $display("FAIL rotation_order[%0d]: got %0d, required %0d",
                         i, (i < order.size()) ? order[i] : -1, expd[i]);
            end
        end
    endtask

    task automatic test_hold_limit();
        int expd[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            tick(8'h03);
            n_checks++;
            if (bus.gnt_valid !== 1'b1 || int'(bus.gnt_idx) != expd[c] || bus.hold_cnt !== 8'(m_hold)) begin
                n_fail++;
                $display("FAIL hold_limit_cycle%0d: idx=%0d hold=%0d, required idx=%0d hold=%0d",
                         c, bus.gnt_idx, bus.hold_cnt, expd[c], m_hold);
            end
        end
    endtask

    task automatic test_sole();
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            tick(8'h10);
            n_checks++;
            if (bus.gnt !== 8'h10) begin
                n_fail++;
                $display("FAIL sole_gnt_cycle%0d: gnt=%h, required 10", c, bus.gnt);
            end
        end
        n_checks++;
        if (bus.hold_cnt !== 8'(MAXH - 1)) begin
            n_fail++;
            $display("FAIL sole_hold_saturate: hold=%0d, required %0d", bus.hold_cnt, MAXH - 1);
        end
    endtask

    task automatic test_release();
        apply_reset();
        tick(8'h40);
        tick(8'h40);
        n_checks++;
        if (bus.gnt !== 8'h40) begin
            n_fail++;
            $display("FAIL release_setup: gnt=%h, required 40", bus.gnt);
        end
        tick(8'h00);
        n_checks++;
        if (bus.gnt_valid !== 1'b0 || bus.gnt !== 8'h00) begin
            n_fail++;
            $display("FAIL release_idle: valid=%b gnt=%h, required valid=0 gnt=00", bus.gnt_valid, bus.gnt);
        end
        tick(8'h00);
        tick(8'h41);
        n_checks++;
        if (bus.gnt_idx !== 3'd0 || bus.gnt !== 8'h01) begin
            n_fail++;
            $display("FAIL release_wrap: idx=%0d gnt=%h, required idx=0 gnt=01", bus.gnt_idx, bus.gnt);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        repeat (3) tick(8'h08);
        n_checks++;
        if (bus.gnt !== 8'h08) begin
            n_fail++;
            $display("FAIL async_setup: gnt=%h, required 08", bus.gnt);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.hold_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL async_clear: gnt=%h valid=%b hold=%0d, required all zero",
                     bus.gnt, bus.gnt_valid, bus.hold_cnt);
        end
        @(negedge clka);
        rst = 1'b0;
        tick(8'h28);
        n_checks++;
        if (bus.gnt_idx !== 3'd3 || bus.gnt !== 8'h08) begin
            n_fail++;
            $display("FAIL async_search_from_0: idx=%0d gnt=%h, required idx=3 gnt=08", bus.gnt_idx, bus.gnt);
        end
    endtask

    task automatic test_random();
        bit [7:0] r;
        apply_reset();
        r = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            else if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 7)] ^= 1'b1;
            tick(r);
            n_checks++;
            if (bus.gnt_valid !== m_valid || bus.gnt !== exp_gnt() || bus.hold_cnt !== 8'(m_hold) ||
                (m_valid && bus.gnt_idx !== 3'(m_idx))) begin
                n_fail++;
                $display("FAIL random_cycle%0d: req=%h valid=%b idx=%0d gnt=%h hold=%0d, required valid=%b idx=%0d gnt=%h hold=%0d",
                         c, r, bus.gnt_valid, bus.gnt_idx, bus.gnt, bus.hold_cnt,
                         m_valid, m_idx, exp_gnt(), m_hold);
            end
        end
    endtask

    initial begin
        bus.req = '0;
        test_reset();
        test_rotation();
        test_hold_limit();
        test_sole();
        test_release();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
